v_tile_simd: RTL and testbench
==============================

Name: v_tile_simd

Overview:
Parametrised successor to the fixed 4x16b vector tile. Per-neighbour operand FIFOs, a config register and a bit-serial-by-lane SIMD adder/subtractor. The adder splits NUM_LANES x LANE_W into groups of 2^mode lanes, so one tile covers 16b/32b/64b/... arithmetic. Results leave over a valid/ready port with backpressure toward the CGRA interconnect.

Parameters:
LANE_W, 16, lane width in bits
NUM_LANES, 4, lane count; power of 2, 1..64
DEPTH, 2, entries per operand FIFO (>=1)
CFG_W, 16, config word width (>=12)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
on_off  in  1  level enable; new ops start only while high
write_en1  in  1  push w_data_in1 into FIFO A
write_rdy1  out  1  FIFO A not full
w_data_in1  in  NUM_LANES*LANE_W  operand A; lane i at [i*LANE_W +: LANE_W]
write_ack1  out  1  one-cycle pulse the cycle after an accepted push
write_en2/write_rdy2/w_data_in2/write_ack2  as above, for FIFO B
write_en3  in  1  write config register
write_rdy3  out  1  config writable (state != EXEC)
w_data_in3  in  CFG_W  config word
write_ack3  out  1  one-cycle pulse after an accepted config write
adder_outputs  out  NUM_LANES*LANE_W  result, same lane packing
dest_info  out  4  destination tag latched at op start
out_valid  out  1  result valid; held until accepted
out_ready  in  1  consumer accepts when out_valid & out_ready
adder_ack  out  1  one-cycle pulse the cycle after a result handshake
busy  out  1  state != IDLE

Behaviour:
- Config fields: [2:0] mode, group size G = 2^min(mode, log2 NUM_LANES). [3] op: 0 add, 1 sub (A-B). [7:4] dest. [8] sat (used only with the optional feature). Other bits are stored and ignored.
- Reset (reset=0, asynchronous): FSM=IDLE. FIFOs are empty. Config=0. Every output is 0 except write_rdy1, write_rdy2 and write_rdy3, which are 1.
- Push is accepted when write_en & write_rdy. A push while not ready is ignored, with no ack. A simultaneous push and pop on a non-full FIFO leaves the count unchanged. No fall-through.
- A config write is accepted when write_en3 & write_rdy3 and takes effect for the next op start. The in-flight op uses the fields latched at its start.
- FSM states: IDLE, EXEC, DONE.
- IDLE -> EXEC on an edge where on_off=1 and both FIFOs are non-empty. On that edge:
  - pop A and B;
  - latch operands, mode, op, sat and dest;
  - slice counter k=0.
- EXEC, one edge per k: for every group, lane (group base + k) is computed as A + (op ? ~B : B) + carry. Carry-in at k=0 is op. Carry is kept per group.
- EXEC -> DONE on the edge where k=G-1. out_valid=1 and adder_outputs, dest_info are updated on that edge.
- Latency from the start edge to out_valid is G cycles (1/2/4 for 16/32/64b with defaults).
- DONE: outputs are held stable. On out_valid & out_ready -> IDLE, out_valid=0, and adder_ack pulses on the next cycle. adder_outputs keep their last value.
- Earliest next start is the edge after the handshake (in IDLE).
- on_off falling mid-op does not abort: the op completes, and no new op starts.
- Arithmetic wraps modulo 2^(G*LANE_W). Carry-out is discarded. Group boundaries block carry.
- Reset asserted in EXEC or DONE aborts the op immediately. The result is lost and no adder_ack is produced.

Optional Feature:
- Macro V_TILE_SAT_EN.
- Defined: when cfg[8]=1, each group result is signed-saturated on the final EXEC edge. Overflow is detected from the sign of A, the effective B and the result. Results clamp to 0111..1 or 1000..0 of group width.
- Undefined: cfg[8] is ignored and all results wrap. Output timing is identical in both builds.

Test Plan:
- cfg=0x0050 (mode0, add, dest5); A={1,2,3,4}; B={10,11,12,13}; on_off=1; out_ready=1 -> out_valid 1 cycle after start; outputs {11,13,15,17}; dest_info=5; adder_ack pulses once.
- cfg mode1 add; A={0xFFFF,0x0001,0xFFFF,0}; B={1,0,0,0} -> {0x0000,0x0002,0xFFFF,0}; latency 2; no carry into group1.
- cfg mode2 sub; A={0,0,0,0}; B={1,0,0,0} -> all lanes 0xFFFF after 4 cycles; write_rdy3=0 during EXEC.
- out_ready=0; push 2 entries to each FIFO, then a 3rd:
  - write_rdy1/2 fall after the 2nd push;
  - 3rd push produces no ack;
  - first result is held stable;
  - the second op starts only after the handshake.
- reset low during k=1 of a mode2 op -> out_valid=0; outputs=0; FIFOs empty; write_rdy*=1; cfg=0.
- mode1 add, cfg[8]=1: lanes0-1 = 0x7FFF_FFFF + 1 -> 0x7FFF_FFFF with V_TILE_SAT_EN, 0x8000_0000 without.

Source files
------------

// File: rtl/v_tile_simd.sv
// Parametrised SIMD vector tile: two operand FIFOs, config register, lane-serial grouped add/sub.
// Optional signed saturation of group results is compiled in with `define V_TILE_SAT_EN.

module v_tile_simd_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         ack
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ack <= 1'b0;
    end else begin
      ack <= do_push;
      if (do_push) wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
      if (do_pop)  rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module v_tile_simd #(
  parameter int LANE_W    = 16,
  parameter int NUM_LANES = 4,
  parameter int DEPTH     = 2,
  parameter int CFG_W     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        on_off,
  input  logic                        write_en1,
  output logic                        write_rdy1,
  input  logic [NUM_LANES*LANE_W-1:0] w_data_in1,
  output logic                        write_ack1,
  input  logic                        write_en2,
  output logic                        write_rdy2,
  input  logic [NUM_LANES*LANE_W-1:0] w_data_in2,
  output logic                        write_ack2,
  input  logic                        write_en3,
  output logic                        write_rdy3,
  input  logic [CFG_W-1:0]            w_data_in3,
  output logic                        write_ack3,
  output logic [NUM_LANES*LANE_W-1:0] adder_outputs,
  output logic [3:0]                  dest_info,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        adder_ack,
  output logic                        busy
);
  localparam int W  = NUM_LANES * LANE_W;
  localparam int LG = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 0;
  localparam int IW = LG + 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nx;

  logic [W-1:0]     a_dout, b_dout;
  logic             a_full, a_empty, b_full, b_empty;
  logic             start, last, cfg_wr;
  logic [CFG_W-1:0] cfg_q;
  logic [W-1:0]     a_q, b_q, acc_q, nx_acc, res;
  logic [NUM_LANES-1:0] carry_q, carry_nx;
  logic [IW-1:0]    gm_q, gm_start, k_q;
  logic             op_q;
  logic [3:0]       dest_q;
  logic             cfg_unused;

  int unsigned      gmi, kqi, base;
  logic             cin;
  logic [LANE_W-1:0] b_eff;
  logic [LANE_W:0]  sum;

  v_tile_simd_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo_a (
    .clk(clk), .reset(reset), .push(write_en1), .pop(start), .din(w_data_in1),
    .dout(a_dout), .full(a_full), .empty(a_empty), .ack(write_ack1)
  );

  v_tile_simd_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo_b (
    .clk(clk), .reset(reset), .push(write_en2), .pop(start), .din(w_data_in2),
    .dout(b_dout), .full(b_full), .empty(b_empty), .ack(write_ack2)
  );

  assign write_rdy1 = ~a_full;
  assign write_rdy2 = ~b_full;
  assign cfg_wr     = write_en3 & write_rdy3;

`ifdef V_TILE_SAT_EN
  logic sat_q;
  assign cfg_unused = ^cfg_q[CFG_W-1:9];
`else
  assign cfg_unused = ^cfg_q[CFG_W-1:8];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)     state_nx = EXEC;
      EXEC:    if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    out_valid  = (state == DONE);
    write_rdy3 = (state != EXEC);
    start      = (state == IDLE) & on_off & ~a_empty & ~b_empty;
    last       = (state == EXEC) & (k_q == gm_q);
  end

  // Group size is 2^min(mode, log2 NUM_LANES); stored as a lane-index mask.
  always_comb begin
    if (cfg_q[2:0] >= 3'(LG)) gm_start = IW'((32'd1 << LG) - 32'd1);
    else                      gm_start = IW'((32'd1 << cfg_q[2:0]) - 32'd1);
  end

  // Each EXEC edge computes lane (base + k) of every group; carry is held at the group's base index.
  always_comb begin
    gmi      = 32'(gm_q);
    kqi      = 32'(k_q);
    nx_acc   = acc_q;
    carry_nx = carry_q;
    base     = 0;
    cin      = 1'b0;
    b_eff    = '0;
    sum      = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if ((i & gmi) == kqi) begin
        base  = i & ~gmi;
        cin   = (kqi == 0) ? op_q : carry_q[base];
        b_eff = op_q ? ~b_q[i*LANE_W +: LANE_W] : b_q[i*LANE_W +: LANE_W];
        sum   = {1'b0, a_q[i*LANE_W +: LANE_W]} + {1'b0, b_eff} + {{LANE_W{1'b0}}, cin};
        nx_acc[i*LANE_W +: LANE_W] = sum[LANE_W-1:0];
        carry_nx[base] = sum[LANE_W];
      end
    end
  end

`ifdef V_TILE_SAT_EN
  int unsigned top;
  logic        sa, sb, sr;

  // Signed overflow per group judged from the top lane's sign bits of A, effective B and the sum.
  always_comb begin
    res = nx_acc;
    top = 0;
    sa  = 1'b0;
    sb  = 1'b0;
    sr  = 1'b0;
    if (sat_q) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        top = i | gmi;
        sa  = a_q[top*LANE_W + LANE_W - 1];
        sb  = b_q[top*LANE_W + LANE_W - 1] ^ op_q;
        sr  = nx_acc[top*LANE_W + LANE_W - 1];
        if ((sa == sb) && (sr != sa))
          res[i*LANE_W +: LANE_W] = (i == top) ? {sa, {(LANE_W-1){~sa}}} : {LANE_W{~sa}};
      end
    end
  end
`else
  assign res = nx_acc;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_q         <= '0;
      write_ack3    <= 1'b0;
      adder_ack     <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      carry_q       <= '0;
      gm_q          <= '0;
      k_q           <= '0;
      op_q          <= 1'b0;
      dest_q        <= '0;
      adder_outputs <= '0;
      dest_info     <= '0;
`ifdef V_TILE_SAT_EN
      sat_q         <= 1'b0;
`endif
    end else begin
      write_ack3 <= cfg_wr;
      adder_ack  <= out_valid & out_ready;
      if (cfg_wr) cfg_q <= w_data_in3;
      if (start) begin
        a_q    <= a_dout;
        b_q    <= b_dout;
        gm_q   <= gm_start;
        op_q   <= cfg_q[3];
        dest_q <= cfg_q[7:4];
        k_q    <= '0;
`ifdef V_TILE_SAT_EN
        sat_q  <= cfg_q[8];
`endif
      end else if (state == EXEC) begin
        k_q     <= k_q + 1'b1;
        acc_q   <= nx_acc;
        carry_q <= carry_nx;
        if (last) begin
          adder_outputs <= res;
          dest_info     <= dest_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_v_tile_simd.sv
// Scoreboard bench for v_tile_simd: directed ops queue expected results; a negedge monitor checks them.
module tb_v_tile_simd;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        on_off = 1'b0;
  logic        write_en1 = 1'b0, write_en2 = 1'b0, write_en3 = 1'b0;
  logic        write_rdy1, write_rdy2, write_rdy3;
  logic [63:0] w_data_in1 = '0, w_data_in2 = '0;
  logic [15:0] w_data_in3 = '0;
  logic        write_ack1, write_ack2, write_ack3;
  logic [63:0] adder_outputs;
  logic [3:0]  dest_info;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        adder_ack;
  logic        busy;

  int checks = 0;
  int failures = 0;
  logic ack_due = 1'b0;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  dest;
  } exp_t;
  exp_t exp_q[$];

  v_tile_simd dut (
    .clk(clk), .reset(reset), .on_off(on_off),
    .write_en1(write_en1), .write_rdy1(write_rdy1), .w_data_in1(w_data_in1), .write_ack1(write_ack1),
    .write_en2(write_en2), .write_rdy2(write_rdy2), .w_data_in2(w_data_in2), .write_ack2(write_ack2),
    .write_en3(write_en3), .write_rdy3(write_rdy3), .w_data_in3(w_data_in3), .write_ack3(write_ack3),
    .adder_outputs(adder_outputs), .dest_info(dest_info), .out_valid(out_valid),
    .out_ready(out_ready), .adder_ack(adder_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] p4(input logic [15:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every result handshake and expects adder_ack exactly one cycle later.
  always @(negedge clk) begin
    if (reset) begin
      chk("adder_ack", {63'd0, adder_ack}, {63'd0, ack_due});
      ack_due = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=%h expected=none", adder_outputs);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result", adder_outputs, e.data);
          chk("dest_info", {60'd0, dest_info}, {60'd0, e.dest});
        end
        ack_due = 1'b1;
      end
    end else begin
      ack_due = 1'b0;
    end
  end

  task automatic write_cfg(input logic [15:0] w);
    write_en3 = 1'b1;
    w_data_in3 = w;
    tick();
    write_en3 = 1'b0;
    chk("write_ack3", {63'd0, write_ack3}, 64'd1);
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] b, input logic accepted);
    write_en1 = 1'b1;
    write_en2 = 1'b1;
    w_data_in1 = a;
    w_data_in2 = b;
    tick();
    write_en1 = 1'b0;
    write_en2 = 1'b0;
    chk("write_ack1", {63'd0, write_ack1}, {63'd0, accepted});
    chk("write_ack2", {63'd0, write_ack2}, {63'd0, accepted});
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
      if (busy && !out_valid) chk("write_rdy3_exec", {63'd0, write_rdy3}, 64'd0);
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL out_valid_timeout actual=0 expected=1");
    end
  endtask

  task automatic run_op(input logic [15:0] cfg, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] res, input logic [3:0] dest, input int g);
    int n;
    write_cfg(cfg);
    exp_q.push_back({res, dest});
    push(a, b, 1'b1);
    wait_valid(n);
    chk("latency", 64'(n), 64'(g + 1));
    tick();
    chk("valid_cleared", {63'd0, out_valid}, 64'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_outputs", adder_outputs, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rdy", {61'd0, write_rdy1, write_rdy2, write_rdy3}, 64'h7);
    chk("rst_acks", {60'd0, write_ack1, write_ack2, write_ack3, adder_ack}, 64'd0);
    tick();
    reset = 1'b1;
    on_off = 1'b1;
    out_ready = 1'b1;
    tick();

    run_op(16'h0050, p4(1, 2, 3, 4), p4(10, 11, 12, 13), p4(11, 13, 15, 17), 4'd5, 1);
    run_op(16'h0001, p4(16'hFFFF, 1, 16'hFFFF, 0), p4(1, 0, 0, 0), p4(0, 2, 16'hFFFF, 0), 4'd0, 2);
    run_op(16'h003A, 64'd0, p4(1, 0, 0, 0), {4{16'hFFFF}}, 4'd3, 4);

    // Backpressure with two full FIFOs and a rejected third push.
    on_off = 1'b0;
    out_ready = 1'b0;
    write_cfg(16'h0070);
    exp_q.push_back({p4(3, 3, 3, 3), 4'd7});
    exp_q.push_back({p4(30, 30, 30, 30), 4'd7});
    push(p4(1, 1, 1, 1), p4(2, 2, 2, 2), 1'b1);
    chk("rdy1_after_1", {63'd0, write_rdy1}, 64'd1);
    push(p4(10, 10, 10, 10), p4(20, 20, 20, 20), 1'b1);
    chk("rdy_full", {62'd0, write_rdy1, write_rdy2}, 64'd0);
    push(p4(99, 99, 99, 99), p4(99, 99, 99, 99), 1'b0);
    on_off = 1'b1;
    wait_valid(n);
    chk("latency_bp", 64'(n), 64'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_valid", {63'd0, out_valid}, 64'd1);
      chk("held_data", adder_outputs, p4(3, 3, 3, 3));
      chk("held_rdy1", {63'd0, write_rdy1}, 64'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_idle_after_hs", {62'd0, out_valid, busy}, 64'd0);
    tick();
    chk("bp_second_start", {63'd0, busy}, 64'd1);
    tick();
    chk("bp_second_valid", {63'd0, out_valid}, 64'd1);
    tick();
    tick();

    // on_off dropped mid-op: current op finishes, queued op waits.
    on_off = 1'b0;
    exp_q.push_back({p4(6, 7, 8, 9), 4'd7});
    exp_q.push_back({p4(1, 0, 0, 0), 4'd7});
    push(p4(5, 6, 7, 8), p4(1, 1, 1, 1), 1'b1);
    push(p4(16'hFFFF, 0, 0, 0), p4(2, 0, 0, 0), 1'b1);
    on_off = 1'b1;
    tick();
    on_off = 1'b0;
    tick();
    chk("onoff_valid", {63'd0, out_valid}, 64'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("onoff_no_start", {63'd0, busy}, 64'd0);
    end
    on_off = 1'b1;
    wait_valid(n);
    chk("latency_onoff", 64'(n), 64'd2);
    tick();
    tick();

    // Reset during k=1 of a mode2 op.
    write_cfg(16'h0002);
    push(p4(1, 2, 3, 4), p4(1, 1, 1, 1), 1'b1);
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("abort_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_outputs", adder_outputs, 64'd0);
    chk("abort_dest", {60'd0, dest_info}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_rdy", {61'd0, write_rdy1, write_rdy2, write_rdy3}, 64'h7);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_fifo_empty", {63'd0, busy}, 64'd0);
    end
    exp_q.push_back({p4(16'h11, 16'h22, 16'h33, 16'h44), 4'd0});
    push(p4(16'h10, 16'h20, 16'h30, 16'h40), p4(1, 2, 3, 4), 1'b1);
    wait_valid(n);
    chk("latency_cfg_cleared", 64'(n), 64'd2);
    tick();
    tick();

`ifdef V_TILE_SAT_EN
    run_op(16'h0161, p4(16'hFFFF, 16'h7FFF, 5, 0), p4(1, 0, 6, 0), p4(16'hFFFF, 16'h7FFF, 11, 0), 4'd6, 2);
`else
    run_op(16'h0161, p4(16'hFFFF, 16'h7FFF, 5, 0), p4(1, 0, 6, 0), p4(0, 16'h8000, 11, 0), 4'd6, 2);
`endif

    tick();
    tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
